// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and rebuilds the displayed
// BCD word and per-digit decimal points. A frame is published once every digit has been sampled.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int N_DIGITS       = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [6:0]              segments,
  input  logic                    dp_in,
  input  logic [N_DIGITS-1:0]     anodos,
  output logic [4*N_DIGITS-1:0]   bcd_out,
  output logic [N_DIGITS-1:0]     dp_out,
  output logic                    frame_valid,
  output logic                    frame_changed,
  output logic                    pattern_err,
  output logic                    scan_lost
);

  localparam int              VW        = N_DIGITS + 8;
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_C  = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // Returns {undecodable, nibble}; blank maps to F, anything unknown to E.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode_seg = {1'b0, 4'h0};
      7'b1001111: decode_seg = {1'b0, 4'h1};
      7'b0010010: decode_seg = {1'b0, 4'h2};
      7'b0000110: decode_seg = {1'b0, 4'h3};
      7'b1001100: decode_seg = {1'b0, 4'h4};
      7'b0100100: decode_seg = {1'b0, 4'h5};
      7'b0100000: decode_seg = {1'b0, 4'h6};
      7'b0001111: decode_seg = {1'b0, 4'h7};
      7'b0000000: decode_seg = {1'b0, 4'h8};
      7'b0000100: decode_seg = {1'b0, 4'h9};
      7'b1111111: decode_seg = {1'b0, 4'hF};
      default:    decode_seg = {1'b1, 4'hE};
    endcase
  endfunction

  logic [6:0]            seg_meta_r, seg_sync_r;
  logic                  dp_meta_r, dp_sync_r;
  logic [N_DIGITS-1:0]   an_meta_r, an_sync_r;
  logic [VW-1:0]         cur_s, prev_r;
  logic                  anode_ok_s;
  logic [N_DIGITS-1:0]   sel_s;
  logic [4:0]            dec_s;

  state_t                state_r, state_nxt_s;
  logic [7:0]            count_r, count_nxt_s;
  logic                  sample_s;

  logic [4*N_DIGITS-1:0] digit_buf_r;
  logic [N_DIGITS-1:0]   dp_buf_r;
  logic [N_DIGITS-1:0]   seen_r, seen_nxt_s;
  logic                  publish_s;
  logic                  perr_nxt_s;
  logic [TW-1:0]         to_cnt_r, to_nxt_s;
  logic                  to_hit_s;
  logic                  lost_nxt_s;

  assign cur_s      = {an_sync_r, seg_sync_r, dp_sync_r};
  assign anode_ok_s = ($countones(~an_sync_r) == 32'd1);
  assign sel_s      = ~an_sync_r;
  assign dec_s      = decode_seg(seg_sync_r);
  assign publish_s  = &seen_r;

  // Two-flop synchronizer for the display bus, plus the one-cycle-old copy used for stability.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seg_meta_r <= 7'h7F;
      seg_sync_r <= 7'h7F;
      dp_meta_r  <= 1'b1;
      dp_sync_r  <= 1'b1;
      an_meta_r  <= '1;
      an_sync_r  <= '1;
      prev_r     <= '1;
    end else begin
      seg_meta_r <= segments;
      seg_sync_r <= seg_meta_r;
      dp_meta_r  <= dp_in;
      dp_sync_r  <= dp_meta_r;
      an_meta_r  <= anodos;
      an_sync_r  <= an_meta_r;
      prev_r     <= cur_s;
    end
  end

  // Dwell FSM: a digit is sampled once after it has been stable for SETTLE_CYCLES.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    sample_s    = 1'b0;
    if (!anode_ok_s) begin
      state_nxt_s = ST_IDLE;
      count_nxt_s = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_SETTLING;
          count_nxt_s = 8'd1;
        end
        ST_SETTLING: begin
          if (cur_s == prev_r) begin
            count_nxt_s = count_r + 8'd1;
          end else begin
            count_nxt_s = 8'd1;
          end
        end
        ST_HELD: begin
          if (cur_s != prev_r) begin
            state_nxt_s = ST_SETTLING;
            count_nxt_s = 8'd1;
          end else begin
            count_nxt_s = 8'd0;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = 8'd0;
        end
      endcase
      if ((state_nxt_s == ST_SETTLING) && (count_nxt_s >= SETTLE_C)) begin
        sample_s    = 1'b1;
        state_nxt_s = ST_HELD;
        count_nxt_s = 8'd0;
      end else begin
        sample_s    = 1'b0;
      end
    end
  end

  // Dwell FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
      count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Publishing/timeout clear the seen mask first so a same-cycle sample lands in the fresh frame.
  always_comb begin
    to_hit_s   = (!sample_s) && (to_cnt_r == (TIMEOUT_C - TW'(1)));
    seen_nxt_s = seen_r;
    perr_nxt_s = pattern_err;
    to_nxt_s   = to_cnt_r;
    lost_nxt_s = scan_lost;
    if (publish_s || to_hit_s) begin
      seen_nxt_s = '0;
    end else begin
      seen_nxt_s = seen_r;
    end
    if (publish_s) begin
      perr_nxt_s = 1'b0;
    end else begin
      perr_nxt_s = pattern_err;
    end
    if (sample_s) begin
      seen_nxt_s = seen_nxt_s | sel_s;
      perr_nxt_s = perr_nxt_s | dec_s[4];
      to_nxt_s   = '0;
      lost_nxt_s = 1'b0;
    end else if (to_cnt_r != TIMEOUT_C) begin
      to_nxt_s   = to_cnt_r + TW'(1);
      lost_nxt_s = scan_lost | to_hit_s;
    end else begin
      to_nxt_s   = to_cnt_r;
      lost_nxt_s = scan_lost;
    end
  end

  // Frame assembly buffers, published outputs and scan-loss watchdog.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit_buf_r   <= '0;
      dp_buf_r      <= '0;
      seen_r        <= '0;
      bcd_out       <= '0;
      dp_out        <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      pattern_err   <= 1'b0;
      scan_lost     <= 1'b0;
      to_cnt_r      <= '0;
    end else begin
      if (publish_s) begin
        bcd_out       <= digit_buf_r;
        dp_out        <= dp_buf_r;
        frame_valid   <= 1'b1;
        frame_changed <= (digit_buf_r != bcd_out);
      end else begin
        frame_valid   <= 1'b0;
        frame_changed <= 1'b0;
      end
      for (int i = 0; i < N_DIGITS; i++) begin
        if (sample_s && sel_s[i]) begin
          digit_buf_r[4*i +: 4] <= dec_s[3:0];
          dp_buf_r[i]           <= ~dp_sync_r;
        end
      end
      seen_r      <= seen_nxt_s;
      pattern_err <= perr_nxt_s;
      scan_lost   <= lost_nxt_s;
      to_cnt_r    <= to_nxt_s;
    end
  end

endmodule
